// File: rtl/housekeeping_spi_master_if.sv
// Host-side request/response bundle for housekeeping_spi_master.
// master = requesting logic, slave = the SPI host engine.
interface housekeeping_spi_master_if;
    logic       start;
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [2:0] nbytes;
    logic [7:0] wdata;
    logic       stop;
    logic       wdata_next;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       busy;
    logic       done;

    modport master (
        output start, wr, rd, addr, nbytes, wdata, stop,
        input  wdata_next, rdata, rdata_valid, busy, done
    );

    modport slave (
        input  start, wr, rd, addr, nbytes, wdata, stop,
        output wdata_next, rdata, rdata_valid, busy, done
    );
endinterface

// File: rtl/housekeeping_spi_master.sv
// SPI host for the housekeeping SPI protocol, mode 0, MSB first.
// Define HKSPI_MASTER_STREAM_EN to allow nbytes==0 streaming ended by stop.
module housekeeping_spi_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                           clk,
    input  logic                           csb_reset,
    housekeeping_spi_master_if.slave       host,
    output logic                           CSB,
    output logic                           SCK,
    output logic                           SDO,
    input  logic                           SDI
);

    typedef enum logic [2:0] {
        IDLE, SETUP, SHIFT, HOLD, GAP
    } state_t;

    typedef enum logic [1:0] {
        PH_CMD, PH_ADDR, PH_DATA
    } phase_t;

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    state_t     state;
    phase_t     phase;
    logic [7:0] timer;
    logic       hi;
    logic [2:0] bit_cnt;
    logic [2:0] byte_cnt;
    logic       wr_q;
    logic       rd_q;
    logic [7:0] addr_q;
    logic [2:0] nb_q;
    logic [7:0] sh_out;
    logic [7:0] sh_in;
    logic       rv_pend;
    logic       stop_seen;
    logic       busy_q;
    logic       done_q;
    logic       wnext_q;
    logic       rvalid_q;
    logic [7:0] rdata_q;
    logic       start_ok;
    logic       last_byte;

    assign host.busy        = busy_q;
    assign host.done        = done_q;
    assign host.wdata_next  = wnext_q;
    assign host.rdata_valid = rvalid_q;
    assign host.rdata       = rdata_q;

`ifdef HKSPI_MASTER_STREAM_EN
    assign start_ok  = host.start;
    assign last_byte = (nb_q == 3'd0) ? (stop_seen | host.stop)
                                      : (byte_cnt == nb_q - 3'd1);
`else
    assign start_ok  = host.start && (host.nbytes != 3'd0);
    assign last_byte = (byte_cnt == nb_q - 3'd1);
`endif

    always_ff @(posedge clk or posedge csb_reset) begin
        if (csb_reset) begin
            state     <= IDLE;
            phase     <= PH_CMD;
            timer     <= 8'd0;
            hi        <= 1'b0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 3'd0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= 8'h00;
            nb_q      <= 3'd0;
            sh_out    <= 8'h00;
            sh_in     <= 8'h00;
            rv_pend   <= 1'b0;
            stop_seen <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wnext_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 8'h00;
            CSB       <= 1'b1;
            SCK       <= 1'b0;
            SDO       <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            wnext_q  <= 1'b0;
            rvalid_q <= 1'b0;
            if (rv_pend) begin
                rdata_q  <= sh_in;
                rvalid_q <= 1'b1;
                rv_pend  <= 1'b0;
            end
`ifdef HKSPI_MASTER_STREAM_EN
            if (busy_q && host.stop)
                stop_seen <= 1'b1;
`endif
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        wr_q      <= host.wr;
                        rd_q      <= host.rd;
                        addr_q    <= host.addr;
                        nb_q      <= host.nbytes;
                        sh_out    <= {host.wr, host.rd, host.nbytes, 3'b000};
                        SDO       <= host.wr;
                        CSB       <= 1'b0;
                        busy_q    <= 1'b1;
                        phase     <= PH_CMD;
                        bit_cnt   <= 3'd0;
                        byte_cnt  <= 3'd0;
                        hi        <= 1'b0;
                        stop_seen <= 1'b0;
                        timer     <= RELOAD;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (timer != 8'd0) begin
                        timer <= timer - 8'd1;
                    end else begin
                        timer <= RELOAD;
                        hi    <= 1'b0;
                        SDO   <= sh_out[7];
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (timer != 8'd0) begin
                        timer <= timer - 8'd1;
                    end else if (!hi) begin
                        // SDI sampled on the clk that raises SCK
                        SCK   <= 1'b1;
                        hi    <= 1'b1;
                        timer <= RELOAD;
                        sh_in <= {sh_in[6:0], SDI};
                        if (phase == PH_DATA && bit_cnt == 3'd7)
                            rv_pend <= rd_q;
                    end else begin
                        SCK   <= 1'b0;
                        hi    <= 1'b0;
                        timer <= RELOAD;
                        if (bit_cnt != 3'd7) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            sh_out  <= {sh_out[6:0], 1'b0};
                            SDO     <= sh_out[6];
                        end else begin
                            bit_cnt <= 3'd0;
                            unique case (1'b1)
                                phase == PH_CMD: begin
                                    phase  <= PH_ADDR;
                                    sh_out <= addr_q;
                                    SDO    <= addr_q[7];
                                end
                                phase == PH_DATA && last_byte: begin
                                    SDO   <= 1'b0;
                                    state <= HOLD;
                                end
                                default: begin
                                    if (phase == PH_DATA)
                                        byte_cnt <= byte_cnt + 3'd1;
                                    phase   <= PH_DATA;
                                    sh_out  <= wr_q ? host.wdata : 8'h00;
                                    SDO     <= wr_q & host.wdata[7];
                                    wnext_q <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                HOLD: begin
                    if (timer != 8'd0) begin
                        timer <= timer - 8'd1;
                    end else begin
                        CSB    <= 1'b1;
                        done_q <= 1'b1;
                        timer  <= RELOAD;
                        state  <= GAP;
                    end
                end
                GAP: begin
                    if (timer != 8'd0) begin
                        timer <= timer - 8'd1;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
